// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter - IF/DM arbiter for one variable-latency memory port
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 16,
  parameter int IF_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  output logic              o_if_stall,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_dm_ready,
  output logic              o_dm_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_err
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_IF_ACC = 2'd1;
  localparam logic [1:0] c_ST_DM_ACC = 2'd2;
  localparam logic [1:0] c_ST_RESP   = 2'd3;

  localparam int c_WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int c_STARVE_W = $clog2(IF_MAX_WAIT + 1);

  localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST  = c_WAIT_W'(TIMEOUT - 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(IF_MAX_WAIT);
  localparam logic [DATA_W-1:0]     c_ABORT_DATA = DATA_W'(32'hDEADBEEF);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  r_win_dm;
  logic [c_WAIT_W-1:0]   r_wait_cnt;
  logic [c_STARVE_W-1:0] r_starve_cnt;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_dm_rdata;
  logic                  r_if_ready;
  logic                  r_dm_ready;
  logic                  r_err;

  logic w_grant_if;
  logic w_grant_dm;
  logic w_in_acc;
  logic w_expire;
  logic w_mem_req_nxt;
  logic w_if_ready_nxt;
  logic w_dm_ready_nxt;
  logic w_err_nxt;

  // DM has priority unless IF has already been passed over IF_MAX_WAIT times
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_dm = 1'b0;
    if (r_state == c_ST_IDLE) begin
      if (i_if_req && (!i_dm_req || (r_starve_cnt == c_STARVE_MAX))) begin
        w_grant_if = 1'b1;
      end else if (i_dm_req) begin
        w_grant_dm = 1'b1;
      end
    end
  end

  assign w_in_acc = (r_state == c_ST_IF_ACC) || (r_state == c_ST_DM_ACC);
  assign w_expire = w_in_acc && !i_mem_ack && (r_wait_cnt == c_WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_grant_if) begin
          w_next_state = c_ST_IF_ACC;
        end else if (w_grant_dm) begin
          w_next_state = c_ST_DM_ACC;
        end
      end
      c_ST_IF_ACC, c_ST_DM_ACC: begin
        if (i_mem_ack || w_expire) begin
          w_next_state = c_ST_RESP;
        end
      end
      c_ST_RESP: w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  // Handshake outputs are computed one cycle ahead and registered below
  always_comb begin
    w_mem_req_nxt  = (w_next_state == c_ST_IF_ACC) || (w_next_state == c_ST_DM_ACC);
    w_if_ready_nxt = w_in_acc && (w_next_state == c_ST_RESP) && !r_win_dm;
    w_dm_ready_nxt = w_in_acc && (w_next_state == c_ST_RESP) && r_win_dm;
    w_err_nxt      = w_expire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req  <= 1'b0;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_mem_req  <= w_mem_req_nxt;
      r_if_ready <= w_if_ready_nxt;
      r_dm_ready <= w_dm_ready_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_dm     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      if (w_grant_if) begin
        r_win_dm    <= 1'b0;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= i_if_addr;
        r_mem_wdata <= '0;
      end else if (w_grant_dm) begin
        r_win_dm    <= 1'b1;
        r_mem_we    <= i_dm_we;
        r_mem_addr  <= i_dm_addr;
        r_mem_wdata <= i_dm_wdata;
      end

      if (w_grant_if || w_grant_dm) begin
        r_wait_cnt <= '0;
      end else if (w_in_acc && !i_mem_ack) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      // A write completion leaves the load-data register untouched
      if (w_in_acc && i_mem_ack) begin
        if (!r_win_dm) begin
          r_if_rdata <= i_mem_rdata;
        end else if (!r_mem_we) begin
          r_dm_rdata <= i_mem_rdata;
        end
      end else if (w_expire) begin
        if (r_win_dm) begin
          r_dm_rdata <= c_ABORT_DATA;
        end else begin
          r_if_rdata <= c_ABORT_DATA;
        end
      end

      if (w_grant_if || ((r_state == c_ST_IDLE) && !i_if_req)) begin
        r_starve_cnt <= '0;
      end else if (w_grant_dm && (r_starve_cnt != c_STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_if_ready  = r_if_ready;
  assign o_dm_ready  = r_dm_ready;
  assign o_err       = r_err;
  assign o_if_stall  = i_if_req && !r_if_ready;
  assign o_dm_stall  = i_dm_req && !r_dm_ready;

endmodule

`default_nettype wire
